// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/mem/writeback and stalls on mem_ready.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       Ext_op,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JMP    = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  state_e state_q, state_d;

  logic ready;
  logic is_r, is_jr, is_lw, is_sw, is_beq;
  logic is_addi, is_addiu, is_lui, is_j, is_legal;

  assign ready    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign is_r     = (opcode == 6'b000000);
  assign is_jr    = is_r && (funct == 6'b001000);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_addi  = (opcode == 6'b001000);
  assign is_addiu = (opcode == 6'b001001);
  assign is_lui   = (opcode == 6'b001111);
  assign is_j     = (opcode == 6'b000010);
  assign is_legal = is_r | is_lw | is_sw | is_beq | is_addi
                  | is_addiu | is_lui | is_j;

  // Next-state selection; unused codes fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_jr)                      state_d = S_JR;
        else if (is_r)                  state_d = S_REX;
        else if (is_lw || is_sw)        state_d = S_MEMADR;
        else if (is_beq)                state_d = S_BEQ;
        else if (is_addi || is_addiu || is_lui)
                                        state_d = S_IEX;
        else if (is_j)                  state_d = S_JMP;
        else if (TRAP_ILLEGAL)          state_d = S_TRAP;
        else                            state_d = S_FETCH;
      end
      S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
      S_REX:    state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_IEX:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_JR:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  logic pcw_d, pcc_d, mr_d, mw_d, irw_d, rw_d;

  // Moore output decode; only FETCH/MEMWR/DECODE/IEX look past the state.
  always_comb begin
    pcw_d      = 1'b0;
    pcc_d      = 1'b0;
    mr_d       = 1'b0;
    mw_d       = 1'b0;
    irw_d      = 1'b0;
    rw_d       = 1'b0;
    IorD       = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    Ext_op     = 1'b0;
    PCSource   = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mr_d    = 1'b1;
        ALUSrcB = 2'b01;
        irw_d   = ready;
        pcw_d   = ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        Ext_op     = 1'b1;
        instr_done = !is_legal && !TRAP_ILLEGAL;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Ext_op  = 1'b1;
      end
      S_MEMRD: begin
        mr_d = 1'b1;
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        rw_d       = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mw_d       = 1'b1;
        IorD       = 1'b1;
        instr_done = ready;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        rw_d       = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        pcc_d      = 1'b1;
        PCSource   = 2'b01;
        instr_done = 1'b1;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = is_lui ? 2'b11 : 2'b00;
        Ext_op  = !is_lui;
      end
      S_IWB: begin
        rw_d       = 1'b1;
        instr_done = 1'b1;
      end
      S_JMP: begin
        pcw_d      = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_JR: begin
        pcw_d      = 1'b1;
        PCSource   = 2'b11;
        instr_done = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset suppresses every write enable in the same cycle.
  assign PCWrite     = pcw_d & ~rst;
  assign PCWriteCond = pcc_d & ~rst;
  assign MemRead     = mr_d  & ~rst;
  assign MemWrite    = mw_d  & ~rst;
  assign IRWrite     = irw_d & ~rst;
  assign RegWrite    = rw_d  & ~rst;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an instruction-level model.
// Three instances cover default, NOP-on-illegal and no-handshake builds.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b1;
  logic [5:0] op_s [3];
  logic [5:0] fn_s [3];
  logic [2:0][18:0] ctl;
  logic [2:0][3:0] st;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_controller #(
      .MEM_HANDSHAKE(g != 2),
      .TRAP_ILLEGAL (g != 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (op_s[g]),
      .funct      (fn_s[g]),
      .mem_ready  (mem_ready),
      .PCWrite    (ctl[g][18]),
      .PCWriteCond(ctl[g][17]),
      .IorD       (ctl[g][16]),
      .MemRead    (ctl[g][15]),
      .MemWrite   (ctl[g][14]),
      .IRWrite    (ctl[g][13]),
      .MemtoReg   (ctl[g][12]),
      .RegWrite   (ctl[g][11]),
      .RegDst     (ctl[g][10]),
      .ALUSrcA    (ctl[g][9]),
      .Ext_op     (ctl[g][8]),
      .PCSource   (ctl[g][7:6]),
      .ALUSrcB    (ctl[g][5:4]),
      .ALUOp      (ctl[g][3:2]),
      .state      (st[g]),
      .instr_done (ctl[g][1]),
      .illegal    (ctl[g][0])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam int PLEN = 256;
  logic [11:0] prog [PLEN];
  int idx [3];
  int ms [3];
  logic [15:0] rem [3];
  int nrem [3];
  int lcnt [3];
  bit lat_on;

  function automatic bit legal(logic [5:0] op);
    return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd9, 6'd15, 6'd2};
  endfunction

  function automatic int lat(logic [5:0] op, logic [5:0] fn);
    if (op == 6'd35) return 5;
    if (op == 6'd0 && fn == 6'd8) return 3;
    if (op inside {6'd4, 6'd2}) return 3;
    if (legal(op)) return 4;
    return 2;
  endfunction

  // Remaining states after DECODE, low nibble first: {count, list}.
  function automatic logic [17:0] path(int k, logic [5:0] op, logic [5:0] fn);
    case (op)
      6'd35:       return {2'd3, 16'h0432};
      6'd43:       return {2'd2, 16'h0052};
      6'd4:        return {2'd1, 16'h0008};
      6'd2:        return {2'd1, 16'h000b};
      6'd8, 6'd9,
      6'd15:       return {2'd2, 16'h00a9};
      6'd0:        return (fn == 6'd8) ? {2'd1, 16'h000c}
                                       : {2'd2, 16'h0076};
      default:     return (k == 1) ? 18'd0 : {2'd1, 16'h000d};
    endcase
  endfunction

  function automatic logic [18:0] exp_ctl(int k, int s, logic [5:0] op,
                                          logic rdy, logic r);
    logic pcw, pcc, iord, mr, mw, irw, m2r, rw, rd, asa, ext, dn, ill, eff;
    logic [1:0] pcs, asb, aop;
    {pcw, pcc, iord, mr, mw, irw, m2r, rw, rd, asa, ext, dn, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    eff = (k == 2) ? 1'b1 : rdy;
    case (s)
      0:  begin mr = 1; asb = 2'b01; irw = eff; pcw = eff; end
      1:  begin asb = 2'b11; ext = 1; dn = (k == 1) && !legal(op); end
      2:  begin asa = 1; asb = 2'b10; ext = 1; end
      3:  begin mr = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; dn = 1; end
      5:  begin mw = 1; iord = 1; dn = eff; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; dn = 1; end
      8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; dn = 1; end
      9:  begin
            asa = 1; asb = 2'b10;
            aop = (op == 6'd15) ? 2'b11 : 2'b00;
            ext = (op != 6'd15);
          end
      10: begin rw = 1; dn = 1; end
      11: begin pcw = 1; pcs = 2'b10; dn = 1; end
      12: begin pcw = 1; pcs = 2'b11; dn = 1; end
      13: ill = 1;
      default: ;
    endcase
    if (r) {pcw, pcc, mr, mw, irw, rw} = '0;
    return {pcw, pcc, iord, mr, mw, irw, m2r, rw, rd, asa, ext,
            pcs, asb, aop, dn, ill};
  endfunction

  task automatic pop(int k);
    if (nrem[k] == 0) ms[k] = 0;
    else begin
      ms[k] = int'(rem[k][3:0]);
      rem[k] = rem[k] >> 4;
      nrem[k]--;
    end
  endtask

  task automatic step(int k, logic r, logic rdy);
    logic eff;
    logic [17:0] p;
    eff = (k == 2) ? 1'b1 : rdy;
    if (r) begin
      ms[k] = 0;
      nrem[k] = 0;
    end else if (ms[k] == 13) begin
      ms[k] = 13;
    end else if ((ms[k] == 0 || ms[k] == 3 || ms[k] == 5) && !eff) begin
      ms[k] = ms[k];
    end else if (ms[k] == 0) begin
      ms[k] = 1;
    end else if (ms[k] == 1) begin
      p = path(k, op_s[k], fn_s[k]);
      nrem[k] = int'(p[17:16]);
      rem[k] = p[15:0];
      idx[k] = (idx[k] + 1) % PLEN;
      pop(k);
    end else begin
      pop(k);
    end
  endtask

  task automatic tick(logic r, logic rdy);
    logic [11:0] w;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (ms[k] == 0) begin
        w = prog[idx[k]];
        op_s[k] = w[11:6];
        fn_s[k] = w[5:0];
      end
    end
    rst = r;
    mem_ready = rdy;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("state[%0d]", k), 32'(st[k]), 32'(ms[k]));
      chk($sformatf("ctl[%0d] s%0d", k, ms[k]), 32'(ctl[k]),
          32'(exp_ctl(k, ms[k], op_s[k], rdy, r)));
      lcnt[k] = (ms[k] == 0) ? 1 : lcnt[k] + 1;
      if (lat_on && !r && ctl[k][1])
        chk($sformatf("latency[%0d] op%0d", k, op_s[k]),
            32'(lcnt[k]), 32'(lat(op_s[k], fn_s[k])));
    end
    for (int k = 0; k < 3; k++) step(k, r, rdy);
  endtask

  function automatic logic [11:0] rnd_instr();
    logic [5:0] ops [8];
    logic [5:0] op, fn;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd9, 6'd15, 6'd2};
    if ($urandom_range(0, 3) == 0) op = 6'($urandom);
    else op = ops[$urandom_range(0, 7)];
    fn = 6'($urandom);
    if (op == 6'd0 && $urandom_range(0, 3) == 0) fn = 6'd8;
    return {op, fn};
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      op_s[k] = '0; fn_s[k] = '0;
      idx[k] = 0; ms[k] = 0; rem[k] = '0; nrem[k] = 0; lcnt[k] = 0;
    end
    prog[0] = {6'b100011, 6'd0};
    prog[1] = {6'b101011, 6'd0};
    prog[2] = {6'b000000, 6'b100000};
    prog[3] = {6'b000000, 6'b001000};
    prog[4] = {6'b000100, 6'd0};
    prog[5] = {6'b000010, 6'd0};
    prog[6] = {6'b001111, 6'd0};
    prog[7] = {6'b001000, 6'd0};
    prog[8] = {6'b001001, 6'd0};
    prog[9] = {6'b111111, 6'd0};
    for (int i = 10; i < PLEN; i++) prog[i] = rnd_instr();

    lat_on = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    lat_on = 1'b1;
    repeat (48) tick(1'b0, 1'b1);
    lat_on = 1'b0;
    tick(1'b1, 1'b1);
    // Stalled SW in MEMWR and a reset while MEMRD is stalled.
    repeat (6) tick(1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3000)
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
